// File: rtl/compa_pkg.sv
// Shared types and helpers for the compa_8bit magnitude comparator.
// Holds the default width, the result encoding and the cascade priority rule.
package compa_pkg;

    parameter int COMPA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        CMP_EQ,
        CMP_GT,
        CMP_LT
    } cmp_res_t;

    // Priority applied when the local operands are equal: equal, then greater, then less.
    function automatic cmp_res_t cascade_resolve(
        input logic eqin,
        input logic gtin,
        input logic ltin
    );
        cmp_res_t res;
        if (eqin) begin
            res = CMP_EQ;
        end else if (gtin) begin
            res = CMP_GT;
        end else if (ltin) begin
            res = CMP_LT;
        end else begin
            res = CMP_EQ;
        end
        return res;
    endfunction

    // Result bits ordered {eq, gt, lt}.
    function automatic logic [2:0] res_to_onehot(input cmp_res_t res);
        logic [2:0] bits;
        case (res)
            CMP_GT:  bits = 3'b010;
            CMP_LT:  bits = 3'b001;
            default: bits = 3'b100;
        endcase
        return bits;
    endfunction

    function automatic logic cascade_is_onehot(
        input logic eqin,
        input logic gtin,
        input logic ltin
    );
        logic [2:0] v;
        v = {eqin, gtin, ltin};
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

endpackage

// File: rtl/compa_core.sv
// Combinational unsigned magnitude compare of two WIDTH-bit operands.
// The first differing bit, scanning from the MSB down, decides the result.
module compa_core
    import compa_pkg::*;
#(
    parameter int WIDTH = COMPA_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic [WIDTH-1:0] bit_gt;
    logic [WIDTH-1:0] bit_lt;
    logic             gt_c;
    logic             lt_c;
    logic             decided_c;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bit_gt[gi] = a[gi] & ~b[gi];
            assign bit_lt[gi] = ~a[gi] & b[gi];
        end
    endgenerate

    always_comb begin
        gt_c      = 1'b0;
        lt_c      = 1'b0;
        decided_c = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!decided_c) begin
                if (bit_gt[i]) begin
                    gt_c      = 1'b1;
                    decided_c = 1'b1;
                end else if (bit_lt[i]) begin
                    lt_c      = 1'b1;
                    decided_c = 1'b1;
                end
            end
        end
    end

    assign gt = gt_c;
    assign lt = lt_c;
    assign eq = ~decided_c;

endmodule

// File: rtl/compa_8bit.sv
// Registered magnitude comparator with 74x85-style cascade inputs (1-cycle latency).
// Optional cascade one-hot error flag: define COMPA8BIT_CASC_ERR_EN to add casc_err.
module compa_8bit
    import compa_pkg::*;
#(
    parameter int WIDTH = COMPA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             aeqbin,
    input  logic             agtbin,
    input  logic             altbin,
    input  logic             in_valid,
    output logic             aeqb,
    output logic             agtb,
    output logic             altb,
`ifdef COMPA8BIT_CASC_ERR_EN
    output logic             casc_err,
`endif
    output logic             out_valid
);

    logic       core_gt;
    logic       core_lt;
    logic       core_eq;
    cmp_res_t   res_c;
    logic [2:0] res_d;
    logic [2:0] res_q;
    logic       valid_q;

    compa_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (a),
        .b  (b),
        .gt (core_gt),
        .lt (core_lt),
        .eq (core_eq)
    );

    // Cascade inputs only matter when the local slice is equal.
    always_comb begin
        res_c = CMP_EQ;
        if (core_eq) begin
            res_c = cascade_resolve(aeqbin, agtbin, altbin);
        end else if (core_gt) begin
            res_c = CMP_GT;
        end else if (core_lt) begin
            res_c = CMP_LT;
        end
    end

    always_comb begin
        res_d = res_q;
        if (in_valid) begin
            res_d = res_to_onehot(res_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= 3'b000;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= in_valid;
        end
    end

    assign aeqb      = res_q[2];
    assign agtb      = res_q[1];
    assign altb      = res_q[0];
    assign out_valid = valid_q;

`ifdef COMPA8BIT_CASC_ERR_EN
    logic casc_err_d;
    logic casc_err_q;

    always_comb begin
        casc_err_d = casc_err_q;
        if (in_valid) begin
            casc_err_d = ~cascade_is_onehot(aeqbin, agtbin, altbin);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            casc_err_q <= 1'b0;
        end else begin
            casc_err_q <= casc_err_d;
        end
    end

    assign casc_err = casc_err_q;
`endif

endmodule

// File: tb/tb_compa_8bit.sv
// Self-checking bench for compa_8bit: vector table, hold/back-to-back/reset sequences,
// and a scoreboard queue of expected results popped when out_valid is seen.
module tb_compa_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       aeqbin;
    logic       agtbin;
    logic       altbin;
    logic       in_valid;
    logic       aeqb;
    logic       agtb;
    logic       altb;
    logic       out_valid;
    logic       casc_err_w;

    compa_8bit #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .aeqbin    (aeqbin),
        .agtbin    (agtbin),
        .altbin    (altbin),
        .in_valid  (in_valid),
        .aeqb      (aeqb),
        .agtb      (agtb),
        .altb      (altb),
`ifdef COMPA8BIT_CASC_ERR_EN
        .casc_err  (casc_err_w),
`endif
        .out_valid (out_valid)
    );

`ifndef COMPA8BIT_CASC_ERR_EN
    assign casc_err_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] cas;   // {aeqbin, agtbin, altbin}
        logic [2:0] res;   // {aeqb, agtb, altb}
        logic       err;
    } vec_t;

    typedef struct {
        logic [2:0] res;
        logic       err;
    } exp_t;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t held;
    logic exp_valid;
    logic checker_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Independent reference: plain unsigned compare plus the cascade priority rule.
    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] cas);
        exp_t e;
        if (ma > mb)      e.res = GT;
        else if (ma < mb) e.res = LT;
        else if (cas[2])  e.res = EQ;
        else if (cas[1])  e.res = GT;
        else if (cas[0])  e.res = LT;
        else              e.res = EQ;
        e.err = !(cas == 3'b100 || cas == 3'b010 || cas == 3'b001);
        return e;
    endfunction

    task automatic drive(input logic [7:0] da, input logic [7:0] db, input logic [2:0] cas,
                         input logic valid, input logic [2:0] res, input logic err);
        exp_t e;
        @(negedge clk);
        a        = da;
        b        = db;
        {aeqbin, agtbin, altbin} = cas;
        in_valid = valid;
        if (valid) begin
            e.res = res;
            e.err = err;
            exp_q.push_back(e);
            $display("drive a=%02h b=%02h cas=%03b exp=%03b err=%0b", da, db, cas, res, err);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) exp_valid = in_valid;
    end

    always @(negedge clk) begin
        if (rst_n && checker_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow: actual=out_valid required=no_result t=%0t", $time);
                end else begin
                    held = exp_q.pop_front();
                end
            end
            check(exp_valid ? "result" : "hold_result", {29'd0, aeqb, agtb, altb}, {29'd0, held.res});
`ifdef COMPA8BIT_CASC_ERR_EN
            check(exp_valid ? "casc_err" : "hold_casc_err", {31'd0, casc_err_w}, {31'd0, held.err});
`endif
            $display("result out_valid=%0b eq/gt/lt=%0b%0b%0b casc_err=%0b", out_valid, aeqb, agtb, altb, casc_err_w);
        end
    end

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{8'hC6, 8'h33, 3'b100, GT, 1'b0};
        vecs[1]  = '{8'hC6, 8'hF3, 3'b000, LT, 1'b1};
        vecs[2]  = '{8'hC6, 8'hEF, 3'b100, LT, 1'b0};
        vecs[3]  = '{8'hC6, 8'hC6, 3'b100, EQ, 1'b0};
        vecs[4]  = '{8'hC6, 8'hC6, 3'b010, GT, 1'b0};
        vecs[5]  = '{8'hC6, 8'hC6, 3'b001, LT, 1'b0};
        vecs[6]  = '{8'hC6, 8'hC6, 3'b000, EQ, 1'b1};
        vecs[7]  = '{8'hC6, 8'hC6, 3'b011, GT, 1'b1};
        vecs[8]  = '{8'h00, 8'hFF, 3'b100, LT, 1'b0};
        vecs[9]  = '{8'hFF, 8'h00, 3'b100, GT, 1'b0};
        vecs[10] = '{8'h00, 8'h00, 3'b100, EQ, 1'b0};
        vecs[11] = '{8'hFF, 8'hFF, 3'b100, EQ, 1'b0};
        vecs[12] = '{8'h5A, 8'h5A, 3'b111, EQ, 1'b1};
        vecs[13] = '{8'h01, 8'h00, 3'b001, GT, 1'b0};

        rst_n      = 1'b0;
        a          = '0;
        b          = '0;
        {aeqbin, agtbin, altbin} = 3'b000;
        in_valid   = 1'b0;
        exp_valid  = 1'b0;
        checker_en = 1'b0;
        held.res   = 3'b000;
        held.err   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {28'd0, aeqb, agtb, altb, out_valid}, 32'd0);
        check("reset_casc_err", {31'd0, casc_err_w}, 32'd0);
        rst_n      = 1'b1;
        checker_en = 1'b1;

        // Table vectors back-to-back: one result per cycle.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cas, 1'b1, vecs[i].res, vecs[i].err);
        end

        // in_valid low for 3 cycles while operands move: results must hold.
        drive(8'h10, 8'h20, 3'b100, 1'b1, LT, 1'b0);
        drive(8'hF0, 8'h01, 3'b000, 1'b0, EQ, 1'b0);
        drive(8'h33, 8'h33, 3'b010, 1'b0, EQ, 1'b0);
        drive(8'h80, 8'h7F, 3'b111, 1'b0, EQ, 1'b0);

        // Random back-to-back traffic, with operand equality forced often.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [2:0] rc;
            exp_t       e;
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 2) == 0) ? ra : 8'($urandom_range(0, 255));
            rc = 3'($urandom_range(0, 7));
            e  = model(ra, rb, rc);
            drive(ra, rb, rc, ($urandom_range(0, 3) != 0), e.res, e.err);
        end

        // Mid-stream reset: a sampled-next result is discarded, outputs clear at once.
        drive(8'hAA, 8'h55, 3'b000, 1'b1, GT, 1'b1);
        drive(8'h55, 8'hAA, 3'b000, 1'b1, LT, 1'b1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_reset_outputs", {28'd0, aeqb, agtb, altb, out_valid}, 32'd0);
        check("async_reset_casc_err", {31'd0, casc_err_w}, 32'd0);
        exp_q.delete();
        exp_valid = 1'b0;
        held.res  = 3'b000;
        held.err  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_held_over_edge", {28'd0, aeqb, agtb, altb, out_valid}, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_released_before_edge", {28'd0, aeqb, agtb, altb, out_valid}, 32'd0);

        // One idle cycle after release keeps zeros, then normal operation resumes.
        drive(8'h12, 8'h34, 3'b100, 1'b0, EQ, 1'b0);
        drive(8'hC6, 8'h33, 3'b100, 1'b1, GT, 1'b0);
        drive(8'h00, 8'h00, 3'b001, 1'b1, LT, 1'b0);
        drive(8'h00, 8'h00, 3'b000, 1'b0, EQ, 1'b0);
        drive(8'h00, 8'h00, 3'b000, 1'b0, EQ, 1'b0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
